// File: rtl/matvec_pkg.sv
// Shared types and constants for the matrix-vector sequencer.
package matvec_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_OUT,
        S_DONE
    } seq_state_t;

    // Width of the go-to-done performance counter
    localparam int PERF_W = 16;

    // Accumulator width: room for products plus growth over the row length
    function automatic int acc_width(input int data_width);
        return 3 * data_width;
    endfunction

endpackage

// File: rtl/en_skew.sv
// Skewed enable wavefront: a MAC_COUNT-deep shift register. Stage 0 takes the
// inject bit, stage i follows stage i-1 one cycle later. Clear empties it.
module en_skew #(
    parameter int MAC_COUNT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inject,
    input  logic                 clear,
    output logic [MAC_COUNT-1:0] en
);

    logic [MAC_COUNT-1:0] en_reg;
    logic [MAC_COUNT-1:0] en_next;

    genvar gi;
    generate
        for (gi = 0; gi < MAC_COUNT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign en_next[gi] = inject;
            end else begin : g_tail
                assign en_next[gi] = en_reg[gi-1];
            end
        end
    endgenerate

    // Shift the wavefront one row per cycle, or flush it on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg <= '0;
        end else if (clear) begin
            en_reg <= '0;
        end else begin
            en_reg <= en_next;
        end
    end

    assign en = en_reg;

endmodule

// File: rtl/matvec_sequencer.sv
// Control sequencer for the systolic matrix-vector MAC array: waits for a full
// operand set, clears the accumulators, drives the skewed enable/read wavefront,
// then captures and streams out the row results over valid/ready.
// Optional feature macro: MATVEC_SEQ_PERF_EN (go-to-done cycle counter).
module matvec_sequencer
    import matvec_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAC_COUNT  = 8,
    parameter int VEC_LEN    = 8,
    localparam int ACC_W     = acc_width(DATA_WIDTH),
    localparam int BLW       = $clog2(VEC_LEN + 1),
    localparam int IDX_W     = $clog2(MAC_COUNT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       go,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    input  logic [BLW-1:0]             b_level,
    input  logic [MAC_COUNT-1:0]       a_full_row,
    output logic                       b_rden,
    output logic [MAC_COUNT-1:0]       a_rden,
    output logic                       mac_clr,
    output logic [MAC_COUNT-1:0]       mac_en,
    input  logic [MAC_COUNT*ACC_W-1:0] c_in,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [ACC_W-1:0]           res_data,
    output logic [IDX_W-1:0]           res_idx,
    output logic [PERF_W-1:0]          perf_cycles
);

    localparam int RUN_W   = $clog2(VEC_LEN + MAC_COUNT);
    localparam int RUN_LEN = VEC_LEN + MAC_COUNT - 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_LEN - 1);
    localparam logic [RUN_W-1:0] INJ_LEN  = RUN_W'(VEC_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAC_COUNT - 1);

    seq_state_t       state_reg, state_next;
    logic [RUN_W-1:0] run_cnt_reg, run_cnt_next;
    logic             inject;
    logic             operands_ready;
    logic             beat_xfer;

    logic             busy_reg, done_reg, mac_clr_reg, b_rden_reg, res_valid_reg;
    logic [IDX_W-1:0] res_idx_reg;
    logic [ACC_W-1:0] bank_reg [MAC_COUNT];
    logic [MAC_COUNT-1:0] skew_en;

    assign operands_ready = (b_level >= BLW'(VEC_LEN)) && (&a_full_row);
    assign beat_xfer      = (state_reg == S_OUT) && res_valid_reg && res_ready;

    // Next-state logic; abort overrides every transition, including go in IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (go) state_next = S_WAIT;
            S_WAIT:  if (operands_ready) state_next = S_CLEAR;
            S_CLEAR: state_next = S_RUN;
            S_RUN:   if (run_cnt_reg == RUN_LAST) state_next = S_DRAIN;
            S_DRAIN: state_next = S_OUT;
            S_OUT:   if (beat_xfer && (res_idx_reg == IDX_LAST)) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort) begin
            state_next = S_IDLE;
        end
    end

    // RUN cycle index k and the wavefront inject bit for the cycle after this one
    always_comb begin
        run_cnt_next = '0;
        if ((state_reg == S_RUN) && (state_next == S_RUN)) begin
            run_cnt_next = run_cnt_reg + RUN_W'(1);
        end
        inject = (state_next == S_RUN) && (run_cnt_next < INJ_LEN);
    end

    // State, RUN index and the registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            run_cnt_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            mac_clr_reg   <= 1'b0;
            b_rden_reg    <= 1'b0;
            res_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            run_cnt_reg   <= run_cnt_next;
            busy_reg      <= (state_next != S_IDLE);
            done_reg      <= (state_next == S_DONE);
            mac_clr_reg   <= (state_next == S_CLEAR);
            b_rden_reg    <= inject;
            res_valid_reg <= (state_next == S_OUT);
        end
    end

    // Result beat index: restarts at 0 on every OUT entry, steps per transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_idx_reg <= '0;
        end else if (state_next != S_OUT) begin
            res_idx_reg <= '0;
        end else if (beat_xfer) begin
            res_idx_reg <= res_idx_reg + IDX_W'(1);
        end
    end

    // Result bank: snapshot of the accumulators taken on the DRAIN-to-OUT edge
    genvar gi;
    generate
        for (gi = 0; gi < MAC_COUNT; gi++) begin : g_bank
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bank_reg[gi] <= '0;
                end else if ((state_reg == S_DRAIN) && (state_next == S_OUT)) begin
                    bank_reg[gi] <= c_in[gi*ACC_W +: ACC_W];
                end
            end
        end
    endgenerate

    // One wavefront drives both the per-row MAC enables and the A FIFO pops
    en_skew #(
        .MAC_COUNT (MAC_COUNT)
    ) u_en_skew (
        .clk    (clk),
        .rst_n  (rst_n),
        .inject (inject),
        .clear  (abort),
        .en     (skew_en)
    );

`ifdef MATVEC_SEQ_PERF_EN
    logic [PERF_W-1:0] perf_cnt_reg;
    logic [PERF_W-1:0] perf_cycles_reg;

    // Count from the go-acceptance cycle through every busy cycle, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_reg <= '0;
        end else if (state_reg == S_IDLE) begin
            if (state_next == S_WAIT) begin
                perf_cnt_reg <= PERF_W'(1);
            end
        end else if (perf_cnt_reg != {PERF_W{1'b1}}) begin
            perf_cnt_reg <= perf_cnt_reg + PERF_W'(1);
        end
    end

    // Publish the count only for operations that reach DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_reg <= '0;
        end else if (state_reg == S_DONE) begin
            perf_cycles_reg <= perf_cnt_reg;
        end
    end

    assign perf_cycles = perf_cycles_reg;
`else
    assign perf_cycles = '0;
`endif

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign mac_clr   = mac_clr_reg;
    assign b_rden    = b_rden_reg;
    assign mac_en    = skew_en;
    assign a_rden    = skew_en;
    assign res_valid = res_valid_reg;
    assign res_idx   = res_idx_reg;
    assign res_data  = bank_reg[res_idx_reg];

endmodule

// File: tb/tb_matvec_sequencer.sv
// Directed bench for matvec_sequencer with a small behavioural MAC array model.
module tb_matvec_sequencer;

    localparam int DW    = 8;
    localparam int MC    = 8;
    localparam int VL    = 8;
    localparam int ACC_W = 3 * DW;
    localparam int BLW   = $clog2(VL + 1);
    localparam int IW    = $clog2(MC);

`ifdef MATVEC_SEQ_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               go = 1'b0;
    logic               abort = 1'b0;
    logic               busy, done;
    logic [BLW-1:0]     b_level = '0;
    logic [MC-1:0]      a_full_row = '0;
    logic               b_rden;
    logic [MC-1:0]      a_rden, mac_en;
    logic               mac_clr;
    logic [MC*ACC_W-1:0] c_in;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [ACC_W-1:0]   res_data;
    logic [IW-1:0]      res_idx;
    logic [15:0]        perf_cycles;

    always #5 clk = ~clk;

    matvec_sequencer #(
        .DATA_WIDTH (DW),
        .MAC_COUNT  (MC),
        .VEC_LEN    (VL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .go          (go),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .b_level     (b_level),
        .a_full_row  (a_full_row),
        .b_rden      (b_rden),
        .a_rden      (a_rden),
        .mac_clr     (mac_clr),
        .mac_en      (mac_en),
        .c_in        (c_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_idx     (res_idx),
        .perf_cycles (perf_cycles)
    );

    // Behavioural array: row i accumulates a_val[i]*b_val while mac_en[i] is high
    logic [ACC_W-1:0] acc [MC];
    logic [DW-1:0]    a_val [MC];
    logic [DW-1:0]    b_val;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MC; i++) acc[i] <= '0;
        end else begin
            for (int i = 0; i < MC; i++) begin
                if (mac_clr) acc[i] <= '0;
                else if (mac_en[i]) acc[i] <= acc[i] + ACC_W'(int'(a_val[i]) * int'(b_val));
            end
        end
    end

    always_comb begin
        c_in = '0;
        for (int i = 0; i < MC; i++) c_in[i*ACC_W +: ACC_W] = acc[i];
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ready_mode = 0;

    // Per-operation observations gathered by run_op
    int r_clr, r_en0_first, r_en7_first, r_en7_last, r_brd_first, r_brd_cnt;
    int r_done, r_done_cnt, r_beats, r_stall_bad, r_arden_bad, r_post_abort;
    logic [ACC_W-1:0] r_data [MC];
    int r_idx [MC];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic set_operands(input int a_mode, input int b);
        for (int i = 0; i < MC; i++) a_val[i] = (a_mode == 0) ? DW'(i + 1) : DW'(a_mode);
        b_val = DW'(b);
    endtask

    // Issue go at relative cycle 0 and record what the DUT does until done (+1)
    task automatic run_op(input int max_c, input int raise_cyc, input int abort_cyc);
        logic             pv_stall;
        logic [ACC_W-1:0] pdata;
        logic [IW-1:0]    pidx;
        r_clr = -1; r_en0_first = -1; r_en7_first = -1; r_en7_last = -1;
        r_brd_first = -1; r_brd_cnt = 0; r_done = -1; r_done_cnt = 0;
        r_beats = 0; r_stall_bad = 0; r_arden_bad = 0; r_post_abort = 0;
        for (int i = 0; i < MC; i++) begin
            r_data[i] = '0;
            r_idx[i] = -1;
        end
        pv_stall = 1'b0;
        pdata = '0;
        pidx = '0;
        cyc = 0;
        go = 1'b1;
        while (cyc < max_c) begin
            tick();
            go = 1'b0;
            abort = 1'b0;
            if (cyc == raise_cyc) b_level = BLW'(VL);
            if (cyc == abort_cyc) abort = 1'b1;
            res_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (abort_cyc >= 0 && cyc > abort_cyc &&
                ((|mac_en) || (|a_rden) || b_rden || busy || res_valid || mac_clr))
                r_post_abort++;
            if (mac_clr && r_clr < 0) r_clr = cyc;
            if (mac_en[0] && r_en0_first < 0) r_en0_first = cyc;
            if (mac_en[MC-1]) begin
                if (r_en7_first < 0) r_en7_first = cyc;
                r_en7_last = cyc;
            end
            if (b_rden) begin
                r_brd_cnt++;
                if (r_brd_first < 0) r_brd_first = cyc;
            end
            if (a_rden !== mac_en) r_arden_bad++;
            if (pv_stall && (!res_valid || res_data !== pdata || res_idx !== pidx)) r_stall_bad++;
            if (res_valid && res_ready) begin
                $display("beat cyc=%0d idx=%0d data=%0d", cyc, res_idx, res_data);
                if (r_beats < MC) begin
                    r_data[r_beats] = res_data;
                    r_idx[r_beats] = int'(res_idx);
                end
                r_beats++;
            end
            pv_stall = res_valid && !res_ready;
            pdata = res_data;
            pidx = res_idx;
            if (done) begin
                r_done_cnt++;
                if (r_done < 0) r_done = cyc;
            end
            if (r_done >= 0 && cyc >= r_done + 1) break;
        end
        res_ready = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, b_rden, mac_clr, res_valid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000", {busy, done, b_rden, mac_clr, res_valid});
        end
        total++;
        if (mac_en !== '0 || a_rden !== '0) begin
            bad++;
            $display("FAIL reset_en: got mac_en=%h a_rden=%h want 0", mac_en, a_rden);
        end
        total++;
        if (res_idx !== '0 || res_data !== '0 || perf_cycles !== 16'd0) begin
            bad++;
            $display("FAIL reset_res: got idx=%0d data=%0d perf=%0d want 0", res_idx, res_data, perf_cycles);
        end
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int e;
        set_operands(0, 3);
        a_full_row = '1;
        b_level = BLW'(VL);
        ready_mode = 0;
        run_op(60, -1, -1);
        $display("op basic done_cyc=%0d beats=%0d", r_done, r_beats);
        total++;
        if (r_clr !== 2) begin bad++; $display("FAIL basic_clr: got %0d want 2", r_clr); end
        total++;
        if (r_en0_first !== 3 || r_brd_first !== 3) begin
            bad++;
            $display("FAIL basic_run_start: got en0=%0d brd=%0d want 3", r_en0_first, r_brd_first);
        end
        total++;
        if (r_en7_first !== 10 || r_en7_last !== 17) begin
            bad++;
            $display("FAIL basic_en7: got %0d..%0d want 10..17", r_en7_first, r_en7_last);
        end
        total++;
        if (r_brd_cnt !== 8) begin bad++; $display("FAIL basic_brd_cnt: got %0d want 8", r_brd_cnt); end
        total++;
        if (r_arden_bad !== 0) begin bad++; $display("FAIL basic_arden: got %0d mismatching cycles want 0", r_arden_bad); end
        total++;
        if (r_done !== 27 || r_done_cnt !== 1) begin
            bad++;
            $display("FAIL basic_done: got cyc=%0d pulses=%0d want cyc=27 pulses=1", r_done, r_done_cnt);
        end
        total++;
        if (r_beats !== 8) begin bad++; $display("FAIL basic_beats: got %0d want 8", r_beats); end
        for (int i = 0; i < MC; i++) begin
            e = 24 * (i + 1);
            total++;
            if (r_idx[i] !== i || r_data[i] !== ACC_W'(e)) begin
                bad++;
                $display("FAIL basic_beat%0d: got idx=%0d data=%0d want idx=%0d data=%0d", i, r_idx[i], r_data[i], i, e);
            end
        end
        total++;
        if (perf_cycles !== (PERF_ON ? 16'd27 : 16'd0)) begin
            bad++;
            $display("FAIL basic_perf: got %0d want %0d", perf_cycles, PERF_ON ? 27 : 0);
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_wait();
        set_operands(0, 3);
        a_full_row = '1;
        b_level = BLW'(VL - 1);
        ready_mode = 0;
        run_op(80, 4, -1);
        $display("op wait clr_cyc=%0d run_cyc=%0d done_cyc=%0d", r_clr, r_en0_first, r_done);
        total++;
        if (r_clr !== 5 || r_en0_first !== 6) begin
            bad++;
            $display("FAIL wait_start: got clr=%0d run=%0d want clr=5 run=6", r_clr, r_en0_first);
        end
        total++;
        if (r_done !== 30 || r_beats !== 8 || r_data[0] !== ACC_W'(24)) begin
            bad++;
            $display("FAIL wait_done: got cyc=%0d beats=%0d d0=%0d want 30 8 24", r_done, r_beats, r_data[0]);
        end
        total++;
        if (perf_cycles !== (PERF_ON ? 16'd30 : 16'd0)) begin
            bad++;
            $display("FAIL wait_perf: got %0d want %0d", perf_cycles, PERF_ON ? 30 : 0);
        end
    endtask

    task automatic test_clear_reuse();
        set_operands(2, 3);
        a_full_row = '1;
        b_level = BLW'(VL);
        ready_mode = 0;
        for (int op = 0; op < 2; op++) begin
            run_op(60, -1, -1);
            $display("op reuse%0d done_cyc=%0d beats=%0d", op, r_done, r_beats);
            total++;
            if (r_done !== 27 || r_beats !== 8) begin
                bad++;
                $display("FAIL reuse%0d_done: got cyc=%0d beats=%0d want 27 8", op, r_done, r_beats);
            end
            for (int i = 0; i < MC; i++) begin
                total++;
                if (r_data[i] !== ACC_W'(48)) begin
                    bad++;
                    $display("FAIL reuse%0d_beat%0d: got %0d want 48", op, i, r_data[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        set_operands(0, 3);
        ready_mode = 1;
        run_op(100, -1, -1);
        ready_mode = 0;
        $display("op stall done_cyc=%0d beats=%0d", r_done, r_beats);
        total++;
        if (r_stall_bad !== 0) begin bad++; $display("FAIL stall_hold: got %0d unstable cycles want 0", r_stall_bad); end
        total++;
        if (r_beats !== 8 || r_done !== 43) begin
            bad++;
            $display("FAIL stall_done: got beats=%0d cyc=%0d want 8 43", r_beats, r_done);
        end
        for (int i = 0; i < MC; i++) begin
            total++;
            if (r_idx[i] !== i || r_data[i] !== ACC_W'(24 * (i + 1))) begin
                bad++;
                $display("FAIL stall_beat%0d: got idx=%0d data=%0d want idx=%0d data=%0d", i, r_idx[i], r_data[i], i, 24 * (i + 1));
            end
        end
    endtask

    task automatic test_abort();
        set_operands(0, 3);
        ready_mode = 0;
        run_op(40, -1, 8);
        $display("op abort at_cyc=8 done_pulses=%0d", r_done_cnt);
        total++;
        if (r_en7_last !== 8 && r_en0_first !== 3) begin
            bad++;
            $display("FAIL abort_pre: got en0_first=%0d want 3", r_en0_first);
        end
        total++;
        if (r_post_abort !== 0) begin
            bad++;
            $display("FAIL abort_quiet: got %0d active cycles after abort want 0", r_post_abort);
        end
        total++;
        if (r_done_cnt !== 0 || r_beats !== 0) begin
            bad++;
            $display("FAIL abort_nodone: got pulses=%0d beats=%0d want 0 0", r_done_cnt, r_beats);
        end
        total++;
        if (perf_cycles !== (PERF_ON ? 16'd43 : 16'd0)) begin
            bad++;
            $display("FAIL abort_perf: got %0d want %0d", perf_cycles, PERF_ON ? 43 : 0);
        end
    endtask

    task automatic test_after_abort();
        set_operands(0, 3);
        run_op(60, -1, -1);
        $display("op after_abort done_cyc=%0d beats=%0d", r_done, r_beats);
        total++;
        if (r_done !== 27 || r_beats !== 8) begin
            bad++;
            $display("FAIL after_abort_done: got cyc=%0d beats=%0d want 27 8", r_done, r_beats);
        end
        total++;
        if (r_data[0] !== ACC_W'(24) || r_data[MC-1] !== ACC_W'(192)) begin
            bad++;
            $display("FAIL after_abort_data: got d0=%0d d7=%0d want 24 192", r_data[0], r_data[MC-1]);
        end
    endtask

    task automatic test_go_abort_idle();
        go = 1'b1;
        abort = 1'b1;
        tick();
        go = 1'b0;
        abort = 1'b0;
        $display("op go_abort_idle busy=%b", busy);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL go_abort_idle: busy got %b want 0", busy); end
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || mac_clr !== 1'b0) begin
            bad++;
            $display("FAIL go_abort_idle_later: got busy=%b clr=%b want 0 0", busy, mac_clr);
        end
    endtask

    initial begin
        set_operands(0, 3);
        test_reset();
        test_basic();
        test_wait();
        test_clear_reuse();
        test_stall();
        test_abort();
        test_after_abort();
        test_go_abort_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matvec_sequencer.md
# matvec_sequencer

Control sequencer for the systolic matrix-vector MAC array. It waits until the A-row and B-vector FIFOs hold a complete operand set. It then clears the accumulators and drives the per-row skewed enable and FIFO-read wavefront for one multiply. Finally it captures the MAC_COUNT results and streams them out over a valid/ready port, sitting between the host command interface and the array.

## Interface
- DATA_WIDTH, 8: operand width; accumulator width ACC_W = 3*DATA_WIDTH.
- MAC_COUNT, 8: number of rows/MAC units.
- VEC_LEN, 8: elements per row and per B vector.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- go  in  1  start-of-operation pulse; honoured only in IDLE.
- abort  in  1  synchronous abort; any non-IDLE state goes to IDLE next cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result beat is accepted.
- b_level  in  $clog2(VEC_LEN+1)  entries in the B FIFO.
- a_full_row  in  MAC_COUNT  bit i: row-i A FIFO holds ≥VEC_LEN entries.
- b_rden  out  1  B FIFO pop.
- a_rden  out  MAC_COUNT  per-row A FIFO pop, skewed.
- mac_clr  out  1  accumulator clear to the array.
- mac_en  out  MAC_COUNT  per-row MAC enable, skewed.
- c_in  in  MAC_COUNT x ACC_W  array accumulator outputs.
- res_valid  out  1  result beat valid.
- res_ready  in  1  result consumer ready.
- res_data  out  ACC_W  result of row res_idx.
- res_idx  out  $clog2(MAC_COUNT)  row index of current beat.
- perf_cycles  out  16  go-to-done cycle count of the last completed operation.

## Operation
- States: IDLE, WAIT, CLEAR, RUN, DRAIN, OUT, DONE.
- IDLE → WAIT on go.
- WAIT → CLEAR when b_level≥VEC_LEN and a_full_row is all ones. Otherwise WAIT holds indefinitely.
- CLEAR lasts 1 cycle with mac_clr=1, then → RUN.
- RUN lasts VEC_LEN+MAC_COUNT−1 cycles, indexed by cycle k from 0. The first VEC_LEN cycles inject a 1 into the skew shift register; later cycles inject 0.
  - mac_en[i] = a_rden[i] = 1 exactly for k in [i, i+VEC_LEN−1].
  - b_rden = 1 for k in [0, VEC_LEN−1].
- RUN is not stallable; the WAIT precondition guarantees no underflow.
- DRAIN lasts 1 cycle with all enables low, so the last accumulation registers; then → OUT.
- OUT: c_in is sampled into an internal result register bank on entry. res_data = bank[res_idx], starting at res_idx=0.
  - A beat transfers when res_valid && res_ready; res_idx then increments.
  - After the beat with res_idx=MAC_COUNT−1 → DONE.
  - res_valid holds, with stable data, while res_ready is low.
- DONE asserts done for 1 cycle, then → IDLE.
- abort: next state IDLE. mac_en, a_rden, b_rden and res_valid are low from the next cycle; the skew register clears; no done pulse; FIFOs are not flushed by this block.
- go while busy is ignored. go and abort together in IDLE: abort wins.

## Timing
- Reset values: busy=0, done=0, b_rden=0, a_rden=0, mac_clr=0, mac_en=0, res_valid=0, res_idx=0, res_data=0, perf_cycles=0; state IDLE.
- All outputs are registered except res_data, which is a mux of the bank by res_idx.
- With FIFOs already filled, go at cycle 0 gives:
  - WAIT at 1, CLEAR at 2, RUN at 3..(2+VEC_LEN+MAC_COUNT−1), DRAIN at the next cycle, first res_valid on the cycle after DRAIN.
  - Defaults: RUN is cycles 3–17, DRAIN 18, res_valid from 19; with res_ready=1, done at 27.
- Counters: RUN counter is $clog2(VEC_LEN+MAC_COUNT) bits. perf_cycles saturates at 16'hFFFF.

## Configuration
- MATVEC_SEQ_PERF_EN defined: a 16-bit counter starts on the go acceptance cycle and counts every non-IDLE cycle. perf_cycles loads on done; an abort leaves it unchanged.
- Undefined: the counter is absent and perf_cycles is tied to 0.

## Structure
- Package matvec_pkg holds:
  - state enum seq_state_t;
  - ACC_W derivation;
  - PERF_W=16 constant.
- Sub-module en_skew: a MAC_COUNT-deep enable shift register with inject, clear and parallel outputs. It drives both mac_en and a_rden; b_rden derives from the inject bit.

## Test plan
- Defaults, FIFOs full, res_ready=1, go → mac_en[7] high cycles 10–17, done at cycle 27, 8 beats with res_idx 0..7.
- b_level=7 then 8 three cycles later → remains in WAIT, RUN starts exactly 2 cycles after b_level reaches 8.
- A=all 2, B=all 3 → every res_data = 48; a second op without reset yields 48 again (clear verified).
- res_ready toggled 1 cycle on, 2 off → res_data/res_idx stable while stalled, exactly 8 transfers.
- abort at RUN k=5 → enables low the next cycle, busy low, no done; a following go completes correctly.
- MATVEC_SEQ_PERF_EN defined, first scenario → perf_cycles=27 after done; undefined → 0.
